mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: round-robin with burst locks and read-response routing.
// Optional MEM_ARB_BURST_LIMIT_EN caps each lock at MAX_BURST beats.
module mem_arbiter #(
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned DATA_W    = 64,
  localparam int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic              c0_lock,
  input  logic [DATA_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_valid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic              c1_lock,
  input  logic [DATA_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_valid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_spurious
);

  if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_max_burst_range
    $error("mem_arbiter: MAX_BURST must be within 2..256");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_last;     // client that won the most recent beat
  logic   rd_pend;
  logic   rd_owner;
  logic   post_rst;    // first cycle after reset: responses are ignored
  logic   lock_sel;
  logic   burst_done;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (c0_req && (!c1_req || rr_last)) c0_gnt = 1'b1;
          else if (c1_req)                    c1_gnt = 1'b1;
        end
        LOCK0:   c0_gnt = 1'b1;
        LOCK1:   c1_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // Memory-side request mirrors the granted client.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lock_sel  = 1'b0;
    if (c0_gnt) begin
      mem_req   = c0_req;
      mem_we    = c0_we;
      mem_addr  = c0_addr;
      mem_wdata = c0_wdata;
      lock_sel  = c0_lock;
    end else if (c1_gnt) begin
      mem_req   = c1_req;
      mem_we    = c1_we;
      mem_addr  = c1_addr;
      mem_wdata = c1_wdata;
      lock_sel  = c1_lock;
    end
  end

`ifdef MEM_ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;

  // Entry beat counts as the first beat of the lock.
  assign burst_done = (burst_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    burst_cnt_nxt = burst_cnt;
    if (state_nxt == IDLE) burst_cnt_nxt = '0;
    else if (mem_req)      burst_cnt_nxt = burst_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) burst_cnt <= '0;
    else     burst_cnt <= burst_cnt_nxt;
  end
`else
  assign burst_done = 1'b0;
`endif

  // Lock tracking: a locked beat from IDLE claims the bus until released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req && lock_sel) state_nxt = c1_gnt ? LOCK1 : LOCK0;
      end
      LOCK0, LOCK1: begin
        if (mem_req && (!lock_sel || burst_done)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_last      <= 1'b1;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      post_rst     <= 1'b1;
      err_spurious <= 1'b0;
    end else begin
      state    <= state_nxt;
      post_rst <= 1'b0;
      if (mem_req) rr_last <= c1_gnt;
      rd_pend  <= mem_req && !mem_we;
      rd_owner <= c1_gnt;
      if (mem_valid && !rd_pend && !post_rst) err_spurious <= 1'b1;
    end
  end

  // Response routing; a response landing in a reset cycle is dropped.
  assign c0_valid = !rst && mem_valid && rd_pend && !rd_owner;
  assign c1_valid = !rst && mem_valid && rd_pend &&  rd_owner;
  assign c0_rdata = mem_rdata;
  assign c1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned MAX_BURST = 16;
`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [63:0] addr [2];
  logic [63:0] wdata [2];
  logic [1:0]  gnt, valid;
  logic [63:0] rdata0, rdata1;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_valid;
  logic [63:0] mem_rdata;
  logic        err_spurious;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .c0_req(req[0]), .c0_we(we[0]), .c0_lock(lock[0]),
    .c0_addr(addr[0]), .c0_wdata(wdata[0]),
    .c0_gnt(gnt[0]), .c0_valid(valid[0]), .c0_rdata(rdata0),
    .c1_req(req[1]), .c1_we(we[1]), .c1_lock(lock[1]),
    .c1_addr(addr[1]), .c1_wdata(wdata[1]),
    .c1_gnt(gnt[1]), .c1_valid(valid[1]), .c1_rdata(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .err_spurious(err_spurious)
  );

  // Reference model state: lock owner (-1 none), last winner, pending read owner.
  int          m_lock = -1;
  int          m_pend = -1;
  int          m_cnt  = 0;
  bit          m_last = 1'b1;
  bit          m_err  = 1'b0;
  bit          m_first = 1'b1;
  logic [63:0] m_pend_addr = '0;

  int          e_w;
  bit          e_beat;
  logic [1:0]  e_gnt, e_valid;
  logic        e_mem_req, e_mem_we;
  logic [63:0] e_addr, e_wdata;

  function automatic logic [63:0] resp(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h5a5a_1234_c3c3_8765;
  endfunction

  task automatic predict();
    e_w = -1;
    if (!rst) begin
      if (m_lock >= 0)       e_w = m_lock;
      else if (req == 2'b11) e_w = m_last ? 0 : 1;
      else if (req[0])       e_w = 0;
      else if (req[1])       e_w = 1;
    end
    e_gnt = 2'b00; e_beat = 1'b0; e_mem_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (e_w >= 0) begin
      e_gnt[e_w[0]] = 1'b1;
      e_beat   = req[e_w[0]];
      e_mem_we = we[e_w[0]];
      e_addr   = addr[e_w[0]];
      e_wdata  = wdata[e_w[0]];
    end
    e_mem_req = e_beat;
    e_valid = 2'b00;
    if (!rst && mem_valid && m_pend >= 0) e_valid[m_pend[0]] = 1'b1;
  endtask

  task automatic advance();
    if (rst) begin
      m_lock = -1; m_last = 1'b1; m_pend = -1; m_err = 1'b0; m_first = 1'b1; m_cnt = 0;
    end else begin
      if (mem_valid && m_pend < 0 && !m_first) m_err = 1'b1;
      m_first = 1'b0;
      m_pend = -1;
      if (e_beat) begin
        if (!we[e_w[0]]) begin
          m_pend = e_w;
          m_pend_addr = addr[e_w[0]];
        end
        m_last = e_w[0];
        if (m_lock < 0) begin
          if (lock[e_w[0]]) begin m_lock = e_w; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (!lock[e_w[0]] || (LIMIT && m_cnt == int'(MAX_BURST))) begin
            m_lock = -1; m_cnt = 0;
          end
        end
      end
    end
  endtask

  // Advance one clock; the memory answers reads the model expects to be in flight.
  task automatic next_cycle();
    @(posedge clk);
    advance();
    @(negedge clk);
    mem_valid = (m_pend >= 0);
    mem_rdata = (m_pend >= 0) ? resp(m_pend_addr) : {$urandom, $urandom};
  endtask

  task automatic settle();
    predict();
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; lock = 2'b00;
  endtask

  task automatic do_reset();
    next_cycle(); rst = 1'b1; idle_inputs(); settle();
    next_cycle(); rst = 1'b0; idle_inputs(); settle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b11; mem_valid = 1'b1; mem_rdata = '0;
    settle();
    checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
    checks++; if (valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", valid); else passed++;
    next_cycle(); rst = 1'b1; req = 2'b11; settle();
    checks++; if (err_spurious !== 1'b0) $display("FAIL reset_err: got %b want 0", err_spurious); else passed++;
    checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt2: got %b want 00", gnt); else passed++;
    // A response in the first cycle after reset is ignored entirely.
    next_cycle(); rst = 1'b0; idle_inputs(); mem_valid = 1'b1; settle();
    checks++; if (valid !== 2'b00) $display("FAIL post_rst_valid: got %b want 00", valid); else passed++;
    next_cycle(); settle();
    checks++; if (err_spurious !== 1'b0) $display("FAIL post_rst_err: got %b want 0", err_spurious); else passed++;
  endtask

  task automatic test_alternating_reads();
    logic [1:0]  exp_g, exp_v;
    logic [63:0] exp_a, prev_a;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      req = (i < 4) ? 2'b11 : 2'b00; we = 2'b00; lock = 2'b00;
      addr[0] = 64'h1000 + 64'(i); addr[1] = 64'h2000 + 64'(i);
      settle();
      exp_g = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      exp_a = (i % 2 == 0) ? 64'h1000 + 64'(i) : 64'h2000 + 64'(i);
      exp_v = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
      prev_a = ((i - 1) % 2 == 0) ? 64'h1000 + 64'(i - 1) : 64'h2000 + 64'(i - 1);
      checks++; if (gnt !== exp_g) $display("FAIL alt_gnt[%0d]: got %b want %b", i, gnt, exp_g); else passed++;
      if (i < 4) begin
        checks++; if (mem_addr !== exp_a) $display("FAIL alt_addr[%0d]: got %h want %h", i, mem_addr, exp_a); else passed++;
      end
      checks++; if (valid !== exp_v) $display("FAIL alt_valid[%0d]: got %b want %b", i, valid, exp_v); else passed++;
      if (i > 0) begin
        checks++;
        if (rdata0 !== resp(prev_a) || rdata1 !== resp(prev_a))
          $display("FAIL alt_rdata[%0d]: got %h/%h want %h", i, rdata0, rdata1, resp(prev_a));
        else passed++;
      end
    end
  endtask

  task automatic test_locked_write_burst();
    logic [1:0] exp_g;
    do_reset();
    next_cycle(); req = 2'b01; we = 2'b11; lock = 2'b00; settle();
    checks++; if (gnt !== 2'b01) $display("FAIL lkw_pre_gnt: got %b want 01", gnt); else passed++;
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      req = 2'b11; we = 2'b11;
      lock = {(j < 3) ? 1'b1 : 1'b0, 1'b0};
      addr[1] = 64'h3000 + 64'(j); wdata[1] = 64'hbeef_0000 + 64'(j);
      settle();
      exp_g = (j < 4) ? 2'b10 : 2'b01;
      checks++; if (gnt !== exp_g) $display("FAIL lkw_gnt[%0d]: got %b want %b", j, gnt, exp_g); else passed++;
      checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL lkw_mem[%0d]: got %b want 11", j, {mem_req, mem_we}); else passed++;
      if (j < 4) begin
        checks++; if (mem_wdata !== 64'hbeef_0000 + 64'(j)) $display("FAIL lkw_wdata[%0d]: got %h want %h", j, mem_wdata, 64'hbeef_0000 + 64'(j)); else passed++;
      end
      checks++; if (valid !== 2'b00) $display("FAIL lkw_valid[%0d]: got %b want 00", j, valid); else passed++;
    end
    next_cycle(); idle_inputs(); settle();
    checks++; if ({mem_req, valid} !== 3'b000) $display("FAIL lkw_tail: got %b want 000", {mem_req, valid}); else passed++;
  endtask

  task automatic test_burst_limit();
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < 42; i++) begin
      next_cycle();
      req = 2'b11; we = 2'b11; lock = {1'b0, (i < 40) ? 1'b1 : 1'b0};
      settle();
      if (i == 41)             exp_g = 2'b10;
      else if (LIMIT && (i % 17 == 16)) exp_g = 2'b10;
      else                     exp_g = 2'b01;
      checks++; if (gnt !== exp_g) $display("FAIL burst_gnt[%0d]: got %b want %b", i, gnt, exp_g); else passed++;
    end
  endtask

  task automatic test_spurious();
    do_reset();
    next_cycle(); idle_inputs(); mem_valid = 1'b1; mem_rdata = 64'hdead; settle();
    checks++; if (valid !== 2'b00) $display("FAIL spur_valid: got %b want 00", valid); else passed++;
    for (int k = 0; k < 4; k++) begin
      next_cycle(); req = 2'($urandom); we = 2'b11; lock = 2'b00; settle();
      checks++; if (err_spurious !== 1'b1) $display("FAIL spur_err[%0d]: got %b want 1", k, err_spurious); else passed++;
    end
    do_reset();
    checks++; if (err_spurious !== 1'b0) $display("FAIL spur_clear: got %b want 0", err_spurious); else passed++;
  endtask

  task automatic test_reset_in_lock();
    do_reset();
    next_cycle(); req = 2'b10; we = 2'b00; lock = 2'b10; addr[1] = 64'h4444; settle();
    checks++; if (gnt !== 2'b10) $display("FAIL ril_enter: got %b want 10", gnt); else passed++;
    next_cycle(); rst = 1'b1; req = 2'b11; lock = 2'b11; settle();
    checks++; if ({gnt, mem_req} !== 3'b000) $display("FAIL ril_rst_gnt: got %b want 000", {gnt, mem_req}); else passed++;
    checks++; if (valid !== 2'b00) $display("FAIL ril_rst_valid: got %b want 00", valid); else passed++;
    next_cycle(); rst = 1'b0; req = 2'b11; we = 2'b00; lock = 2'b00; addr[0] = 64'h5555; settle();
    checks++; if (gnt !== 2'b01) $display("FAIL ril_tie: got %b want 01", gnt); else passed++;
    checks++; if (valid !== 2'b00) $display("FAIL ril_drop: got %b want 00", valid); else passed++;
    next_cycle(); idle_inputs(); settle();
    checks++; if (err_spurious !== 1'b0) $display("FAIL ril_err: got %b want 0", err_spurious); else passed++;
    checks++; if (valid !== 2'b01 || rdata0 !== resp(64'h5555)) $display("FAIL ril_resp: got %b/%h want 01/%h", valid, rdata0, resp(64'h5555)); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      rst  = ($urandom_range(0, 99) == 0);
      req  = 2'($urandom);
      we   = 2'($urandom);
      lock = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      for (int c = 0; c < 2; c++) begin
        addr[c]  = {$urandom, $urandom};
        wdata[c] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 63) == 0) mem_valid = 1'b1;
      settle();
      checks++;
      if ({gnt, mem_req, mem_we, valid} !== {e_gnt, e_mem_req, e_mem_we, e_valid})
        $display("FAIL rnd_ctrl[%0d]: got %b want %b", n, {gnt, mem_req, mem_we, valid},
                 {e_gnt, e_mem_req, e_mem_we, e_valid});
      else passed++;
      checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata)
        $display("FAIL rnd_bus[%0d]: got %h/%h want %h/%h", n, mem_addr, mem_wdata, e_addr, e_wdata);
      else passed++;
      checks++;
      if (rdata0 !== mem_rdata || rdata1 !== mem_rdata)
        $display("FAIL rnd_rdata[%0d]: got %h/%h want %h", n, rdata0, rdata1, mem_rdata);
      else passed++;
      checks++;
      if (err_spurious !== m_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, err_spurious, m_err);
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); mem_valid = 1'b0; mem_rdata = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    test_reset();
    test_alternating_reads();
    test_locked_write_burst();
    test_burst_limit();
    test_spurious();
    test_reset_in_lock();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
